// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-slot TDM link; locks to frame_sync and fans slots out to o0..o3.
// Optional macro TDM_FRAME_CNT_EN adds a 16-bit frame_cnt output counting frame_valid pulses.
module tdm_demux4 #(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
`ifdef TDM_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             s0,
    output logic             s1
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // miss_cnt only ever holds 0..MISS_LIMIT-1
    localparam int             MW        = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
    localparam logic [MW-1:0]  MISS_LAST = MW'(MISS_LIMIT - 1);
    localparam logic [MW-1:0]  MISS_ONE  = MW'(1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [WIDTH-1:0] stage0_q, stage0_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic [WIDTH-1:0] o3_q, o3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;
    logic [1:0]       s_q, s_d;
`ifdef TDM_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    // Frame alignment, slot staging and lane update
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        miss_d        = miss_q;
        stage0_d      = stage0_q;
        stage1_d      = stage1_q;
        stage2_d      = stage2_q;
        o0_d          = o0_q;
        o1_d          = o1_q;
        o2_d          = o2_q;
        o3_d          = o3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        stage0_d = din;
                        slot_d   = 2'd1;
                        miss_d   = '0;
                        state_d  = ST_LOCKED;
                    end else begin
                        state_d  = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (frame_sync) begin
                            stage0_d = din;
                            slot_d   = 2'd1;
                            miss_d   = '0;
                        end else if (miss_q == MISS_LAST) begin
                            // Lock lost: sample dropped, lanes keep the last good frame
                            state_d    = ST_HUNT;
                            slot_d     = 2'd0;
                            miss_d     = '0;
                            sync_err_d = 1'b1;
                        end else begin
                            stage0_d = din;
                            slot_d   = 2'd1;
                            miss_d   = miss_q + MISS_ONE;
                        end
                    end else if (frame_sync) begin
                        // Misplaced sync realigns the frame onto this sample
                        stage0_d   = din;
                        slot_d     = 2'd1;
                        miss_d     = '0;
                        sync_err_d = 1'b1;
                    end else begin
                        slot_d = slot_q + 2'd1;
                        case (slot_q)
                            2'd1:    stage1_d = din;
                            2'd2:    stage2_d = din;
                            2'd3: begin
                                o0_d          = stage0_q;
                                o1_d          = stage1_q;
                                o2_d          = stage2_q;
                                o3_d          = din;
                                frame_valid_d = 1'b1;
                            end
                            default: stage0_d = stage0_q;
                        endcase
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = 2'd0;
                    miss_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Status outputs track the next state so they are valid right after each edge
    always_comb begin
        locked_d = (state_d == ST_LOCKED);
        if (state_d == ST_LOCKED) begin
            s_d = slot_d;
        end else begin
            s_d = 2'b00;
        end
    end

`ifdef TDM_FRAME_CNT_EN
    // Frame counter advances with every frame_valid pulse
    always_comb begin
        if (frame_valid_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end
`endif

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HUNT;
            slot_q        <= 2'd0;
            miss_q        <= '0;
            stage0_q      <= '0;
            stage1_q      <= '0;
            stage2_q      <= '0;
            o0_q          <= '0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            s_q           <= 2'b00;
`ifdef TDM_FRAME_CNT_EN
            frame_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            miss_q        <= miss_d;
            stage0_q      <= stage0_d;
            stage1_q      <= stage1_d;
            stage2_q      <= stage2_d;
            o0_q          <= o0_d;
            o1_q          <= o1_d;
            o2_q          <= o2_d;
            o3_q          <= o3_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
            s_q           <= s_d;
`ifdef TDM_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign o0          = o0_q;
    assign o1          = o1_q;
    assign o2          = o2_q;
    assign o3          = o3_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign s0          = s_q[1];
    assign s1          = s_q[0];
`ifdef TDM_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4, MISS_LIMIT=2); frame_cnt checks apply when TDM_FRAME_CNT_EN is defined.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] o0, o1, o2, o3;
    logic       frame_valid, locked, sync_err, s0, s1;
`ifdef TDM_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(4), .MISS_LIMIT(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
`ifdef TDM_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .s0(s0), .s1(s1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, then sample just after the edge
    task automatic send(input logic v, input logic fs, input logic [3:0] d);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; din = 4'h0; din_valid = 1'b0; frame_sync = 1'b0;
        @(posedge clk); #1;
        send(1'b1, 1'b1, 4'hF);
        rst = 1'b0;
        check("rst_lanes", {o0, o1, o2, o3}, 16'h0000);
        check("rst_flags", {12'h000, frame_valid, locked, sync_err, 1'b0}, 16'h0000);
        check("rst_slot", {14'h0000, s0, s1}, 16'h0000);

        // 1: sync+A,B,C,D back-to-back
        send(1'b1, 1'b1, 4'hA);
        check("t1_locked", {15'h0000, locked}, 16'h0001);
        check("t1_slot1", {14'h0000, s0, s1}, 16'h0001);
        send(1'b1, 1'b0, 4'hB);
        check("t1_slot2", {14'h0000, s0, s1}, 16'h0002);
        send(1'b1, 1'b0, 4'hC);
        check("t1_slot3", {14'h0000, s0, s1}, 16'h0003);
        check("t1_no_early_fv", {15'h0000, frame_valid}, 16'h0000);
        send(1'b1, 1'b0, 4'hD);
        check("t1_fv", {15'h0000, frame_valid}, 16'h0001);
        check("t1_lanes", {o0, o1, o2, o3}, 16'hABCD);
        check("t1_wrap", {14'h0000, s0, s1}, 16'h0000);
        send(1'b0, 1'b0, 4'h0);
        check("t1_fv_pulse", {15'h0000, frame_valid}, 16'h0000);
        check("t1_hold", {o0, o1, o2, o3}, 16'hABCD);

        // 2: hunt discards unsynced samples
        rst = 1'b1; send(1'b0, 1'b0, 4'h0); rst = 1'b0;
        send(1'b1, 1'b0, 4'h7);
        send(1'b1, 1'b0, 4'h8);
        send(1'b1, 1'b0, 4'h9);
        check("t2_hunt", {15'h0000, locked}, 16'h0000);
        send(1'b1, 1'b1, 4'h1);
        send(1'b1, 1'b0, 4'h2);
        send(1'b1, 1'b0, 4'h3);
        check("t2_no_fv", {15'h0000, frame_valid}, 16'h0000);
        send(1'b1, 1'b0, 4'h4);
        check("t2_fv", {15'h0000, frame_valid}, 16'h0001);
        check("t2_lanes", {o0, o1, o2, o3}, 16'h1234);

        // 3: misplaced sync at slot 2
        send(1'b1, 1'b1, 4'h5);
        send(1'b1, 1'b0, 4'h6);
        send(1'b1, 1'b1, 4'h9);
        check("t3_sync_err", {15'h0000, sync_err}, 16'h0001);
        check("t3_realign", {14'h0000, s0, s1}, 16'h0001);
        check("t3_still_locked", {15'h0000, locked}, 16'h0001);
        check("t3_hold", {o0, o1, o2, o3}, 16'h1234);
        send(1'b1, 1'b0, 4'hA);
        check("t3_err_pulse", {15'h0000, sync_err}, 16'h0000);
        send(1'b1, 1'b0, 4'hB);
        send(1'b1, 1'b0, 4'hC);
        check("t3_fv", {15'h0000, frame_valid}, 16'h0001);
        check("t3_lanes", {o0, o1, o2, o3}, 16'h9ABC);

        // 4: two frames without sync at slot 0
        send(1'b1, 1'b0, 4'hD);
        send(1'b1, 1'b0, 4'hE);
        send(1'b1, 1'b0, 4'hF);
        send(1'b1, 1'b0, 4'h0);
        check("t4_first_fv", {15'h0000, frame_valid}, 16'h0001);
        check("t4_first_lanes", {o0, o1, o2, o3}, 16'hDEF0);
        check("t4_first_locked", {15'h0000, locked}, 16'h0001);
        send(1'b1, 1'b0, 4'h3);
        check("t4_unlock", {15'h0000, locked}, 16'h0000);
        check("t4_sync_err", {15'h0000, sync_err}, 16'h0001);
        check("t4_slot_hunt", {14'h0000, s0, s1}, 16'h0000);
        check("t4_hold", {o0, o1, o2, o3}, 16'hDEF0);
        send(1'b1, 1'b0, 4'h4);
        check("t4_err_pulse", {14'h0000, sync_err, locked}, 16'h0000);

        // 5: stalls between slots, then reset mid-frame
        send(1'b1, 1'b1, 4'h7);
        send(1'b0, 1'b1, 4'h1);
        check("t5_stall_slot", {14'h0000, s0, s1}, 16'h0001);
        send(1'b1, 1'b0, 4'h8);
        send(1'b0, 1'b0, 4'h0);
        send(1'b0, 1'b1, 4'h2);
        check("t5_stall_slot2", {14'h0000, s0, s1}, 16'h0002);
        send(1'b1, 1'b0, 4'h9);
        send(1'b0, 1'b0, 4'h0);
        send(1'b1, 1'b0, 4'h6);
        check("t5_fv", {15'h0000, frame_valid}, 16'h0001);
        check("t5_lanes", {o0, o1, o2, o3}, 16'h7896);
        send(1'b1, 1'b1, 4'h3);
        send(1'b1, 1'b0, 4'h5);
        rst = 1'b1; send(1'b1, 1'b0, 4'h6); rst = 1'b0;
        check("t5_rst_lanes", {o0, o1, o2, o3}, 16'h0000);
        check("t5_rst_flags", {12'h000, frame_valid, locked, sync_err, s0}, 16'h0000);
        check("t5_rst_s1", {15'h0000, s1}, 16'h0000);
        send(1'b1, 1'b0, 4'h7);
        check("t5_hunt", {15'h0000, locked}, 16'h0000);

`ifdef TDM_FRAME_CNT_EN
        check("fc_rst", frame_cnt, 16'd0);
        for (int f = 0; f < 3; f++) begin
            send(1'b1, 1'b1, 4'h1);
            send(1'b1, 1'b0, 4'h2);
            send(1'b1, 1'b0, 4'h3);
            send(1'b1, 1'b0, 4'h4);
        end
        check("fc_three", frame_cnt, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
